// File: rtl/iterative_div_unit.sv
// Multi-cycle restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Start/busy/valid handshake with flush; result held until next accepted op.
module iterative_div_unit (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        flush,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_res;
  logic        r_is_rem;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_signed;
  logic        w_accept;
  logic        w_dz;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [31:0] w_spec_res;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_fix_q;
  logic [31:0] w_fix_r;

  assign w_signed  = ~opcode[0];
  assign w_accept  = start & ~flush & (opcode[4:2] == 3'b010);
  assign w_dz      = (data2 == 32'd0);
  assign w_ovf     = w_signed & (data1 == 32'h8000_0000)
                   & (data2 == 32'hFFFF_FFFF);
  assign w_special = w_dz | w_ovf;

  assign w_abs1 = (w_signed & data1[31]) ? -data1 : data1;
  assign w_abs2 = (w_signed & data2[31]) ? -data2 : data2;

  always_comb begin
    w_spec_res = 32'd0;
    unique case (1'b1)
      w_dz:  w_spec_res = opcode[1] ? data1 : 32'hFFFF_FFFF;
      w_ovf: w_spec_res = opcode[1] ? 32'd0 : 32'h8000_0000;
      default: w_spec_res = 32'd0;
    endcase
  end

  // Partial remainder stays below the divisor, so the low 32 bits
  // of the difference are exact whenever the trial succeeds.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[31:0] - r_dvs;

  assign w_fix_q = r_neg_q ? -r_quo : r_quo;
  assign w_fix_r = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == 6'd32) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
      r_res    <= 32'd0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_is_rem <= opcode[1];
      r_neg_q  <= w_signed & (data1[31] ^ data2[31]);
      r_neg_r  <= w_signed & data1[31];
      r_quo    <= w_abs1;
      r_dvs    <= w_abs2;
      r_rem    <= 32'd0;
      r_cnt    <= 6'd0;
      if (w_special) r_res <= w_spec_res;
    end else if (r_state == S_CALC && !flush && r_cnt != 6'd32) begin
      r_rem <= w_ge ? w_sub : w_shift[31:0];
      r_quo <= {r_quo[30:0], w_ge};
      r_cnt <= r_cnt + 6'd1;
    end else if (r_state == S_FIX && !flush) begin
      r_res <= r_is_rem ? w_fix_r : w_fix_q;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign valid  = (r_state == S_DONE);
  assign result = r_res;

endmodule

// File: tb/tb_iterative_div_unit.sv
// Bench for iterative_div_unit: vector table, random model ops,
// and hand sequences for flush, reset and back-to-back issue.
module tb_iterative_div_unit;

  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_DIVU = 5'b01001;
  localparam logic [4:0] OP_REM  = 5'b01010;
  localparam logic [4:0] OP_REMU = 5'b01011;
  localparam int LAT_N = 35;
  localparam int LAT_S = 1;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] data1 = 32'd0;
  logic [31:0] data2 = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  iterative_div_unit dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .start  (start),
    .opcode (opcode),
    .data1  (data1),
    .data2  (data2),
    .flush  (flush),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? sa % sb : sa / sb;
    return op[1] ? a % b : a / b;
  endfunction

  task automatic wait_valid(output int n, output logic got);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge CLK);
      n++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int n;
    logic got;
    logic [31:0] e;
    @(negedge CLK);
    start = 1'b1;
    opcode = op;
    data1 = a;
    data2 = b;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    start = 1'b0;
    data1 = $urandom;
    data2 = $urandom;
    wait_valid(n, got);
    e = exp_q.pop_front();
    if (!got) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_res"}, result, e);
      check({name, "_lat"}, n, lat);
      @(negedge CLK);
      check({name, "_pulse"}, {31'd0, valid}, 32'd0);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic no_valid(input string name, input int cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge CLK);
      if (valid) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int n;
    logic got;
    logic [31:0] prev;
    logic [31:0] e;
    logic [4:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{OP_DIV,  32'd100,        32'd7,          32'd14,         LAT_N};
    vecs[1]  = '{OP_REM,  32'd100,        32'd7,          32'd2,          LAT_N};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  LAT_N};
    vecs[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  LAT_N};
    vecs[4]  = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          LAT_N};
    vecs[5]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  LAT_N};
    vecs[6]  = '{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          LAT_N};
    vecs[7]  = '{OP_DIV,  32'hFFFF_FFFF,  32'h10,         32'd0,          LAT_N};
    vecs[8]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  LAT_S};
    vecs[9]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          LAT_S};
    vecs[10] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LAT_S};
    vecs[11] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_S};
    vecs[12] = '{OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  LAT_N};
    vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_N};
    vecs[14] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LAT_N};
    vecs[15] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  LAT_S};

    repeat (2) @(negedge CLK);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", result, 32'd0);
    RESETN = 1'b1;
    @(negedge CLK);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 8; i++) begin
      rop = {3'b010, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 7) rb = 32'd0;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb),
             (rb == 32'd0) ? LAT_S : LAT_N);
    end

    prev = 32'h1234_5678;
    run_op("pre_flush", OP_DIVU, 32'h2468_ACF0, 32'd2, prev, LAT_N);

    @(negedge CLK);
    start = 1'b1;
    opcode = OP_DIV;
    data1 = 32'd100;
    data2 = 32'd7;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    no_valid("flush_novalid", 40);
    check("flush_result", result, prev);

    @(negedge CLK);
    start = 1'b1;
    flush = 1'b1;
    opcode = OP_DIV;
    @(posedge CLK);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("startflush_busy", {31'd0, busy}, 32'd0);
    no_valid("startflush_novalid", 3);

    @(negedge CLK);
    start = 1'b1;
    opcode = 5'b00000;
    @(posedge CLK);
    #1;
    start = 1'b0;
    check("badop_busy", {31'd0, busy}, 32'd0);
    no_valid("badop_novalid", 3);
    check("badop_result", result, prev);

    @(negedge CLK);
    start = 1'b1;
    opcode = OP_DIV;
    data1 = 32'd100;
    data2 = 32'd7;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("midcalc_busy", {31'd0, busy}, 32'd1);
    RESETN = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    no_valid("arst_novalid", 40);

    @(negedge CLK);
    start = 1'b1;
    opcode = OP_DIVU;
    data1 = 32'd1000;
    data2 = 32'd10;
    exp_q.push_back(32'd100);
    @(posedge CLK);
    #1;
    data1 = 32'hFFFF_FFFF;
    data2 = 32'd3;
    exp_q.push_back(32'h5555_5555);
    wait_valid(n, got);
    e = exp_q.pop_front();
    if (!got) check("b2b1_timeout", 32'd0, 32'd1);
    else begin
      check("b2b1_res", result, e);
      check("b2b1_lat", n, LAT_N);
    end
    @(negedge CLK);
    check("b2b_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    check("b2b_accept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    data1 = 32'd0;
    data2 = 32'd0;
    wait_valid(n, got);
    e = exp_q.pop_front();
    if (!got) check("b2b2_timeout", 32'd0, 32'd1);
    else begin
      check("b2b2_res", result, e);
      check("b2b2_lat", n + 1, LAT_N);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
